cu_vertex_cache_fill_module: RTL and testbench

// Fill engine for the CSR PULL PageRank vertex cache: consumes cache-miss read commands, issues them to memory,

---
 rtl/cu_vertex_cache_fill_module.sv | 216 +++++++++++++++++++++
 tb/tb_cu_vertex_cache_fill_module.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_vertex_cache_fill_module.sv
// rtl/cu_vertex_cache_fill_module.sv - miss-status table fill engine for the PageRank vertex cache
// Buses: command {valid, tag[7:0], address_offset[31:0]}, response {valid, tag[7:0], done},
// data {valid, tag[7:0], line[255:0]}, fill {valid, id[31:0], data[31:0]}.
module cu_vertex_cache_fill_module #(
   parameter int MSHR_ENTRIES  = 8,
   parameter int MSHR_IDX_BITS = $clog2(MSHR_ENTRIES),
   parameter int FILL_DELAY    = 0
) (
   input  logic                     clock,
   input  logic                     rstn_in,
   input  logic                     enabled_in,
   input  logic [40:0]              miss_command_in,
   input  logic [9:0]               read_response_in,
   input  logic [264:0]             read_data_0_in,
   input  logic [264:0]             read_data_1_in,
   output logic [40:0]              read_command_out,
   output logic [64:0]              fill_data_out,
   output logic                     miss_ready_out,
   output logic [MSHR_IDX_BITS:0]   outstanding_out,
   output logic                     error_out
);

   localparam int WORD_BITS           = 32;
   localparam int DATA_SIZE_READ_BITS = 3;
   localparam int HALF_BIT            = DATA_SIZE_READ_BITS;
   localparam int CNT_W               = MSHR_IDX_BITS + 1;

   typedef enum logic [1:0] {FREE, PENDING, COLLECT, READY} entry_state_t;

   logic                     rstn_internal;
   logic                     en_q;
   logic [40:0]              miss_q;
   logic [9:0]               resp_q;
   logic [264:0]             d0_q;
   logic [264:0]             d1_q;

   entry_state_t             state      [MSHR_ENTRIES];
   logic [31:0]              saved_addr [MSHR_ENTRIES];
   logic [WORD_BITS-1:0]     saved_word [MSHR_ENTRIES];
   logic [MSHR_ENTRIES-1:0]  got0;
   logic [MSHR_ENTRIES-1:0]  got1;
   logic [MSHR_ENTRIES-1:0]  got_done;

   logic [MSHR_ENTRIES-1:0]  hit0;
   logic [MSHR_ENTRIES-1:0]  hit1;
   logic [MSHR_ENTRIES-1:0]  hit_done;
   logic [MSHR_ENTRIES-1:0]  hit_fail;
   logic [MSHR_ENTRIES-1:0]  free_vec;
   logic                     alloc_found;
   logic                     fill_found;
   logic [MSHR_IDX_BITS-1:0] alloc_idx;
   logic [MSHR_IDX_BITS-1:0] fill_idx;
   logic                     do_alloc;
   logic                     do_fill;
   logic                     drop;
   logic                     fail_any;

   logic [MSHR_IDX_BITS-1:0] idx0;
   logic [MSHR_IDX_BITS-1:0] idx1;
   logic [DATA_SIZE_READ_BITS-1:0] sel0;
   logic [DATA_SIZE_READ_BITS-1:0] sel1;
   logic [WORD_BITS-1:0]     word0;
   logic [WORD_BITS-1:0]     word1;
   logic [64:0]              fill_q;
   logic                     unused_bits;

   // Reset release and enable are registered once; inputs are latched for one cycle.
   always_ff @(posedge clock or negedge rstn_in) begin
      if (!rstn_in) begin
         rstn_internal <= 1'b0;
         en_q          <= 1'b0;
         miss_q        <= '0;
         resp_q        <= '0;
         d0_q          <= '0;
         d1_q          <= '0;
      end else begin
         rstn_internal <= 1'b1;
         en_q          <= enabled_in & rstn_internal;
         miss_q        <= rstn_internal ? miss_command_in  : '0;
         resp_q        <= rstn_internal ? read_response_in : '0;
         d0_q          <= rstn_internal ? read_data_0_in   : '0;
         d1_q          <= rstn_internal ? read_data_1_in   : '0;
      end
   end

   assign idx0  = d0_q[256 +: MSHR_IDX_BITS];
   assign idx1  = d1_q[256 +: MSHR_IDX_BITS];
   assign sel0  = saved_addr[idx0][DATA_SIZE_READ_BITS-1:0];
   assign sel1  = saved_addr[idx1][DATA_SIZE_READ_BITS-1:0];
   assign word0 = d0_q[{sel0, 5'd0} +: WORD_BITS];
   assign word1 = d1_q[{sel1, 5'd0} +: WORD_BITS];

   // Only in-flight entries accept data and responses; FREE entries drop late traffic.
   always_comb begin
      hit0        = '0;
      hit1        = '0;
      hit_done    = '0;
      hit_fail    = '0;
      free_vec    = '0;
      alloc_found = 1'b0;
      alloc_idx   = '0;
      fill_found  = 1'b0;
      fill_idx    = '0;
      for (int i = 0; i < MSHR_ENTRIES; i++) begin
         if (state[i] == PENDING || state[i] == COLLECT) begin
            hit0[i]     = d0_q[264] && (idx0 == MSHR_IDX_BITS'(i));
            hit1[i]     = d1_q[264] && (idx1 == MSHR_IDX_BITS'(i));
            hit_done[i] = resp_q[9] && resp_q[0]
                          && (resp_q[1 +: MSHR_IDX_BITS] == MSHR_IDX_BITS'(i));
            hit_fail[i] = resp_q[9] && !resp_q[0]
                          && (resp_q[1 +: MSHR_IDX_BITS] == MSHR_IDX_BITS'(i));
         end
         if (state[i] == FREE) begin
            free_vec[i] = 1'b1;
            if (!alloc_found) begin
               alloc_found = 1'b1;
               alloc_idx   = MSHR_IDX_BITS'(i);
            end
         end
         if (state[i] == READY && !fill_found) begin
            fill_found = 1'b1;
            fill_idx   = MSHR_IDX_BITS'(i);
         end
      end
   end

   assign do_alloc       = en_q & miss_q[40] & alloc_found;
   assign drop           = en_q & miss_q[40] & ~alloc_found;
   assign do_fill        = en_q & fill_found;
   assign fail_any       = |hit_fail;
   assign miss_ready_out = |free_vec;

   // Allocation looks at start-of-cycle state, so an entry freed this cycle is not reused until next.
   always_ff @(posedge clock or negedge rstn_in) begin
      if (!rstn_in) begin
         for (int i = 0; i < MSHR_ENTRIES; i++) begin
            state[i]      <= FREE;
            saved_addr[i] <= '0;
            saved_word[i] <= '0;
         end
         got0             <= '0;
         got1             <= '0;
         got_done         <= '0;
         read_command_out <= '0;
         fill_q           <= '0;
         outstanding_out  <= '0;
         error_out        <= 1'b0;
      end else begin
         read_command_out <= '0;
         fill_q           <= '0;
         if (do_alloc)
            read_command_out <= {1'b1, miss_q[39:32+MSHR_IDX_BITS], alloc_idx, miss_q[31:0]};
         if (do_fill)
            fill_q <= {1'b1, saved_addr[fill_idx], saved_word[fill_idx]};
         if (drop || fail_any)
            error_out <= 1'b1;
         outstanding_out <= outstanding_out + CNT_W'(do_alloc) - CNT_W'(do_fill) - CNT_W'(fail_any);
         for (int i = 0; i < MSHR_ENTRIES; i++) begin
            case (state[i])
               FREE: begin
                  if (do_alloc && alloc_idx == MSHR_IDX_BITS'(i)) begin
                     state[i]      <= PENDING;
                     saved_addr[i] <= miss_q[31:0];
                     got0[i]       <= 1'b0;
                     got1[i]       <= 1'b0;
                     got_done[i]   <= 1'b0;
                  end
               end
               PENDING, COLLECT: begin
                  got0[i]     <= got0[i] | hit0[i];
                  got1[i]     <= got1[i] | hit1[i];
                  got_done[i] <= got_done[i] | hit_done[i];
                  if (hit0[i] && !saved_addr[i][HALF_BIT])
                     saved_word[i] <= word0;
                  if (hit1[i] && saved_addr[i][HALF_BIT])
                     saved_word[i] <= word1;
                  if (hit_fail[i])
                     state[i] <= FREE;
                  else if ((got0[i] | hit0[i]) && (got1[i] | hit1[i]) && (got_done[i] | hit_done[i]))
                     state[i] <= READY;
                  else if (got0[i] | hit0[i] | got1[i] | hit1[i])
                     state[i] <= COLLECT;
               end
               READY: begin
                  if (do_fill && fill_idx == MSHR_IDX_BITS'(i))
                     state[i] <= FREE;
               end
               default: state[i] <= FREE;
            endcase
         end
      end
   end

   generate
      if (FILL_DELAY == 0) begin : g_no_delay
         assign fill_data_out = fill_q;
      end else begin : g_delay
         logic [64:0] pipe [FILL_DELAY];
         always_ff @(posedge clock or negedge rstn_in) begin
            if (!rstn_in) begin
               for (int s = 0; s < FILL_DELAY; s++)
                  pipe[s] <= '0;
            end else begin
               pipe[0] <= fill_q;
               for (int s = 1; s < FILL_DELAY; s++)
                  pipe[s] <= pipe[s-1];
            end
         end
         assign fill_data_out = pipe[FILL_DELAY-1];
      end
   endgenerate

   assign unused_bits = ^{miss_q[32 +: MSHR_IDX_BITS], resp_q[8:1+MSHR_IDX_BITS],
                          d0_q[263:256+MSHR_IDX_BITS], d1_q[263:256+MSHR_IDX_BITS]};

endmodule

// File: tb/tb_cu_vertex_cache_fill_module.sv
// tb/tb_cu_vertex_cache_fill_module.sv - randomized self-checking bench for the vertex cache fill engine
module tb_cu_vertex_cache_fill_module;

   logic          clock = 1'b0;
   logic          rstn_in = 1'b0;
   logic          enabled_in = 1'b0;
   logic [40:0]   miss_command_in = '0;
   logic [9:0]    read_response_in = '0;
   logic [264:0]  read_data_0_in = '0;
   logic [264:0]  read_data_1_in = '0;
   logic [40:0]   read_command_out;
   logic [64:0]   fill_data_out;
   logic          miss_ready_out;
   logic [3:0]    outstanding_out;
   logic          error_out;

   int total = 0;
   int bad   = 0;

   logic [31:0]   m_addr [8];
   logic [7:0]    m_tag  [8];
   logic [255:0]  m_l0   [8];
   logic [255:0]  m_l1   [8];
   logic [64:0]   fills [$];
   logic [40:0]   cmds  [$];

   cu_vertex_cache_fill_module dut (
      .clock            (clock),
      .rstn_in          (rstn_in),
      .enabled_in       (enabled_in),
      .miss_command_in  (miss_command_in),
      .read_response_in (read_response_in),
      .read_data_0_in   (read_data_0_in),
      .read_data_1_in   (read_data_1_in),
      .read_command_out (read_command_out),
      .fill_data_out    (fill_data_out),
      .miss_ready_out   (miss_ready_out),
      .outstanding_out  (outstanding_out),
      .error_out        (error_out)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (fill_data_out[64])
         fills.push_back(fill_data_out);
      if (read_command_out[40])
         cmds.push_back(read_command_out);
   end

   // The requested vertex word: bit 3 of the id picks the half, bits 2:0 pick the 32-bit word.
   function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic [255:0] l0, input logic [255:0] l1);
      logic [255:0] line;
      line = addr[3] ? l1 : l0;
      return 32'(line >> (32 * addr[2:0]));
   endfunction

   function automatic logic [255:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [7:0] tag_for(input int idx);
      return {5'($urandom_range(0, 31)), 3'(idx)};
   endfunction

   task automatic do_reset();
      rstn_in = 1'b0;
      miss_command_in = '0;
      read_response_in = '0;
      read_data_0_in = '0;
      read_data_1_in = '0;
      repeat (2) @(negedge clock);
      rstn_in = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic send_data(input int half, input int idx, input logic [255:0] line);
      if (half == 0) read_data_0_in = {1'b1, tag_for(idx), line};
      else           read_data_1_in = {1'b1, tag_for(idx), line};
      @(negedge clock);
      read_data_0_in = '0;
      read_data_1_in = '0;
   endtask

   task automatic send_resp(input int idx, input logic done);
      read_response_in = {1'b1, tag_for(idx), done};
      @(negedge clock);
      read_response_in = '0;
   endtask

   task automatic test_reset();
      enabled_in = 1'b1;
      do_reset();
      total++; if (read_command_out !== 41'd0) begin bad++; $display("FAIL reset_cmd got=%0h exp=0", read_command_out); end
      total++; if (fill_data_out !== 65'd0) begin bad++; $display("FAIL reset_fill got=%0h exp=0", fill_data_out); end
      total++; if (miss_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", miss_ready_out); end
      total++; if (outstanding_out !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_out); end
      total++; if (error_out !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b exp=0", error_out); end
   endtask

   task automatic test_single_miss();
      logic [40:0] ecmd;
      logic [64:0] efill;
      m_addr[0] = 32'h45;
      m_tag[0]  = 8'($urandom);
      m_l0[0]   = rand_line();
      m_l1[0]   = rand_line();
      ecmd  = {1'b1, m_tag[0][7:3], 3'd0, m_addr[0]};
      efill = {1'b1, 32'h45, exp_word(m_addr[0], m_l0[0], m_l1[0])};
      miss_command_in = {1'b1, m_tag[0], m_addr[0]};
      @(negedge clock);
      miss_command_in = '0;
      total++; if (read_command_out[40] !== 1'b0) begin bad++; $display("FAIL single_cmd_early got=%0b exp=0", read_command_out[40]); end
      @(negedge clock);
      total++; if (read_command_out !== ecmd) begin bad++; $display("FAIL single_cmd got=%0h exp=%0h", read_command_out, ecmd); end
      send_data(0, 0, m_l0[0]);
      send_data(1, 0, m_l1[0]);
      read_response_in = {1'b1, tag_for(0), 1'b1};
      @(negedge clock);
      read_response_in = '0;
      @(negedge clock);
      total++; if (fill_data_out[64] !== 1'b0) begin bad++; $display("FAIL single_fill_early got=%0b exp=0", fill_data_out[64]); end
      @(negedge clock);
      total++; if (fill_data_out !== efill) begin bad++; $display("FAIL single_fill got=%0h exp=%0h", fill_data_out, efill); end
      total++; if (outstanding_out !== 4'd0) begin bad++; $display("FAIL single_outstanding got=%0d exp=0", outstanding_out); end
   endtask

   task automatic test_out_of_order();
      logic [40:0] ecmd;
      logic [64:0] efill;
      m_addr[0] = $urandom;
      m_tag[0]  = 8'($urandom);
      m_l0[0]   = rand_line();
      m_l1[0]   = rand_line();
      ecmd  = {1'b1, m_tag[0][7:3], 3'd0, m_addr[0]};
      efill = {1'b1, m_addr[0], exp_word(m_addr[0], m_l0[0], m_l1[0])};
      miss_command_in = {1'b1, m_tag[0], m_addr[0]};
      @(negedge clock);
      miss_command_in = '0;
      @(negedge clock);
      total++; if (read_command_out !== ecmd) begin bad++; $display("FAIL ooo_cmd got=%0h exp=%0h", read_command_out, ecmd); end
      send_resp(0, 1'b1);
      send_data(0, 0, m_l0[0]);
      read_data_1_in = {1'b1, tag_for(0), m_l1[0]};
      @(negedge clock);
      read_data_1_in = '0;
      @(negedge clock);
      total++; if (fill_data_out[64] !== 1'b0) begin bad++; $display("FAIL ooo_fill_early got=%0b exp=0", fill_data_out[64]); end
      @(negedge clock);
      total++; if (fill_data_out !== efill) begin bad++; $display("FAIL ooo_fill got=%0h exp=%0h", fill_data_out, efill); end
      @(negedge clock);
      total++; if (outstanding_out !== 4'd0 || miss_ready_out !== 1'b1) begin bad++; $display("FAIL ooo_free got=%0d/%0b exp=0/1", outstanding_out, miss_ready_out); end
   endtask

   task automatic test_full();
      logic [40:0] ecmd;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         m_addr[i % 8] = (i < 8) ? {3'(i), 29'($urandom)} : m_addr[i % 8];
         m_tag[i % 8]  = (i < 8) ? 8'($urandom) : m_tag[i % 8];
      end
      for (int k = 0; k < 11; k++) begin
         if (k < 8)       miss_command_in = {1'b1, m_tag[k], m_addr[k]};
         else if (k == 8) miss_command_in = {1'b1, 8'($urandom), $urandom};
         else             miss_command_in = '0;
         @(negedge clock);
         if (k >= 1 && k <= 8) ecmd = {1'b1, m_tag[k-1][7:3], 3'(k-1), m_addr[k-1]};
         else                  ecmd = '0;
         total++; if (read_command_out !== ecmd) begin bad++; $display("FAIL full_cmd_%0d got=%0h exp=%0h", k, read_command_out, ecmd); end
      end
      total++; if (miss_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", miss_ready_out); end
      total++; if (outstanding_out !== 4'd8) begin bad++; $display("FAIL full_outstanding got=%0d exp=8", outstanding_out); end
      total++; if (error_out !== 1'b1) begin bad++; $display("FAIL full_error got=%0b exp=1", error_out); end
   endtask

   task automatic test_same_cycle();
      logic [64:0] e2;
      logic [64:0] e5;
      for (int i = 0; i < 8; i++) begin
         m_l0[i] = rand_line();
         m_l1[i] = rand_line();
      end
      e2 = {1'b1, m_addr[2], exp_word(m_addr[2], m_l0[2], m_l1[2])};
      e5 = {1'b1, m_addr[5], exp_word(m_addr[5], m_l0[5], m_l1[5])};
      send_data(0, 2, m_l0[2]);
      send_data(1, 5, m_l1[5]);
      send_resp(2, 1'b1);
      send_resp(5, 1'b1);
      read_data_1_in = {1'b1, tag_for(2), m_l1[2]};
      read_data_0_in = {1'b1, tag_for(5), m_l0[5]};
      @(negedge clock);
      read_data_0_in = '0;
      read_data_1_in = '0;
      @(negedge clock);
      total++; if (outstanding_out !== 4'd8) begin bad++; $display("FAIL same_outstanding_8 got=%0d exp=8", outstanding_out); end
      @(negedge clock);
      total++; if (fill_data_out !== e2) begin bad++; $display("FAIL same_fill_2 got=%0h exp=%0h", fill_data_out, e2); end
      total++; if (outstanding_out !== 4'd7) begin bad++; $display("FAIL same_outstanding_7 got=%0d exp=7", outstanding_out); end
      @(negedge clock);
      total++; if (fill_data_out !== e5) begin bad++; $display("FAIL same_fill_5 got=%0h exp=%0h", fill_data_out, e5); end
      total++; if (outstanding_out !== 4'd6) begin bad++; $display("FAIL same_outstanding_6 got=%0d exp=6", outstanding_out); end
      @(negedge clock);
      total++; if (fill_data_out[64] !== 1'b0 || miss_ready_out !== 1'b1) begin bad++; $display("FAIL same_after got=%0b/%0b exp=0/1", fill_data_out[64], miss_ready_out); end
   endtask

   task automatic test_failure();
      logic [40:0] ecmd;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         m_addr[i] = $urandom;
         m_tag[i]  = 8'($urandom);
         miss_command_in = {1'b1, m_tag[i], m_addr[i]};
         @(negedge clock);
      end
      miss_command_in = '0;
      repeat (3) @(negedge clock);
      fills.delete();
      send_resp(3, 1'b0);
      repeat (5) @(negedge clock);
      total++; if (fills.size() !== 0) begin bad++; $display("FAIL fail_nofill got=%0d exp=0", fills.size()); end
      total++; if (outstanding_out !== 4'd3) begin bad++; $display("FAIL fail_outstanding got=%0d exp=3", outstanding_out); end
      total++; if (error_out !== 1'b1) begin bad++; $display("FAIL fail_error got=%0b exp=1", error_out); end
      m_addr[3] = $urandom;
      m_tag[3]  = 8'($urandom);
      ecmd = {1'b1, m_tag[3][7:3], 3'd3, m_addr[3]};
      miss_command_in = {1'b1, m_tag[3], m_addr[3]};
      @(negedge clock);
      miss_command_in = '0;
      @(negedge clock);
      total++; if (read_command_out !== ecmd) begin bad++; $display("FAIL fail_reuse got=%0h exp=%0h", read_command_out, ecmd); end
      @(negedge clock);
      total++; if (outstanding_out !== 4'd4 || error_out !== 1'b1) begin bad++; $display("FAIL fail_sticky got=%0d/%0b exp=4/1", outstanding_out, error_out); end
   endtask

   task automatic test_reset_mid();
      #2;
      rstn_in = 1'b0;
      #1;
      total++; if (outstanding_out !== 4'd0 || miss_ready_out !== 1'b1) begin bad++; $display("FAIL mid_async got=%0d/%0b exp=0/1", outstanding_out, miss_ready_out); end
      @(negedge clock);
      rstn_in = 1'b1;
      repeat (2) @(negedge clock);
      fills.delete();
      for (int i = 0; i < 4; i++) begin
         send_data(0, i, rand_line());
         send_data(1, i, rand_line());
         send_resp(i, 1'b1);
      end
      repeat (5) @(negedge clock);
      total++; if (fills.size() !== 0) begin bad++; $display("FAIL mid_nofill got=%0d exp=0", fills.size()); end
      total++; if (outstanding_out !== 4'd0 || miss_ready_out !== 1'b1) begin bad++; $display("FAIL mid_state got=%0d/%0b exp=0/1", outstanding_out, miss_ready_out); end
      total++; if (error_out !== 1'b0) begin bad++; $display("FAIL mid_error got=%0b exp=0", error_out); end
   endtask

   task automatic test_enable();
      enabled_in = 1'b0;
      repeat (2) @(negedge clock);
      cmds.delete();
      miss_command_in = {1'b1, 8'($urandom), $urandom};
      @(negedge clock);
      miss_command_in = '0;
      repeat (4) @(negedge clock);
      total++; if (cmds.size() !== 0 || outstanding_out !== 4'd0) begin bad++; $display("FAIL enable_low got=%0d/%0d exp=0/0", cmds.size(), outstanding_out); end
      enabled_in = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_random();
      int k;
      int ev [$];
      for (int r = 0; r < 6; r++) begin
         k = $urandom_range(1, 8);
         cmds.delete();
         fills.delete();
         ev.delete();
         for (int i = 0; i < k; i++) begin
            m_addr[i] = {3'(i), 29'($urandom)};
            m_tag[i]  = 8'($urandom);
            m_l0[i]   = rand_line();
            m_l1[i]   = rand_line();
            miss_command_in = {1'b1, m_tag[i], m_addr[i]};
            @(negedge clock);
         end
         miss_command_in = '0;
         repeat (3) @(negedge clock);
         total++; if (cmds.size() !== k) begin bad++; $display("FAIL rand_cmd_count got=%0d exp=%0d", cmds.size(), k); end
         for (int i = 0; i < k && i < cmds.size(); i++) begin
            total++;
            if (cmds[i] !== {1'b1, m_tag[i][7:3], 3'(i), m_addr[i]}) begin
               bad++; $display("FAIL rand_cmd_%0d got=%0h exp=%0h", i, cmds[i], {1'b1, m_tag[i][7:3], 3'(i), m_addr[i]});
            end
         end
         for (int i = 0; i < k; i++)
            for (int t = 0; t < 3; t++)
               ev.push_back(i * 3 + t);
         for (int a = ev.size() - 1; a > 0; a--) begin
            int b;
            int tmp;
            b = $urandom_range(0, a);
            tmp = ev[a]; ev[a] = ev[b]; ev[b] = tmp;
         end
         foreach (ev[a]) begin
            case (ev[a] % 3)
               0: send_data(0, ev[a] / 3, m_l0[ev[a] / 3]);
               1: send_data(1, ev[a] / 3, m_l1[ev[a] / 3]);
               default: send_resp(ev[a] / 3, 1'b1);
            endcase
         end
         repeat (k + 4) @(negedge clock);
         total++; if (fills.size() !== k) begin bad++; $display("FAIL rand_fill_count got=%0d exp=%0d", fills.size(), k); end
         for (int i = 0; i < k; i++) begin
            logic        found;
            logic [31:0] got;
            logic [31:0] exp;
            found = 1'b0;
            got   = '0;
            exp   = exp_word(m_addr[i], m_l0[i], m_l1[i]);
            foreach (fills[f])
               if (fills[f][63:32] == m_addr[i]) begin found = 1'b1; got = fills[f][31:0]; end
            total++;
            if (!found || got !== exp) begin bad++; $display("FAIL rand_fill_%0d found=%0b got=%0h exp=%0h", i, found, got, exp); end
         end
         total++; if (outstanding_out !== 4'd0) begin bad++; $display("FAIL rand_outstanding got=%0d exp=0", outstanding_out); end
      end
   endtask

   initial begin
      test_reset();
      test_single_miss();
      test_out_of_order();
      test_full();
      test_same_cycle();
      test_failure();
      test_reset_mid();
      test_enable();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
